// File: rtl/x25519_pkg.sv
// Shared X25519 types: operand word, pass count and the multiply sequencer states.
package x25519_pkg;

    localparam int X25519_WIDTH      = 264;
    localparam int X25519_NUM_PASSES = 32;

    typedef logic [263:0] x25519_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mult_seq_state_t;

endpackage

// File: rtl/x25519_mult_sequencer.sv
// Drives one MultPass instance through NUM_PASSES passes of a 264-bit multiply,
// summing each pass result (mod 2^WIDTH, no reduction) into an accumulator and
// presenting the total with a one-cycle done pulse. A pass that never returns
// within TIMEOUT cycles of its mp_en aborts the multiply with an err pulse.
module x25519_mult_sequencer
    import x25519_pkg::*;
#(
    parameter int WIDTH      = X25519_WIDTH,
    parameter int NUM_PASSES = X25519_NUM_PASSES,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          ready,
    output logic                          done,
    output logic                          err,
    output logic [WIDTH-1:0]              out,
    output logic                          mp_en,
    output logic [WIDTH-1:0]              mp_a,
    output logic [WIDTH-1:0]              mp_b,
    output logic [$clog2(NUM_PASSES)-1:0] mp_i,
    input  logic                          mp_out_valid,
    input  logic [WIDTH-1:0]              mp_out
);

    localparam int IW = $clog2(NUM_PASSES);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_PASS = IW'(NUM_PASSES - 1);
    localparam logic [IW-1:0] ONE_I     = IW'(1);
    localparam logic [TW-1:0] ONE_T     = TW'(1);
    // r_tmo holds cycles elapsed since mp_en, so hitting TIMEOUT-1 in WAIT
    // places the err pulse exactly TIMEOUT cycles after mp_en.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    mult_seq_state_t  r_state;
    mult_seq_state_t  w_next;

    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             r_mp_en;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_mp_a;
    logic [WIDTH-1:0] r_mp_b;
    logic [IW-1:0]    r_mp_i;
    logic [WIDTH-1:0] r_acc;
    logic [TW-1:0]    r_tmo;

    logic             w_accept;
    logic             w_last;
    logic             w_timeout;
    logic [WIDTH-1:0] w_sum;

    // Accumulator adder: plain truncating add, the carry out is discarded.
    assign w_sum = r_acc + mp_out;

    // Next-state decode plus the accept/last-pass/timeout qualifiers.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_last    = (r_mp_i == LAST_PASS);
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end else begin
                    w_next   = IDLE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (mp_out_valid) begin
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next = ISSUE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_next    = WAIT;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end else begin
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered handshake outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_mp_en <= 1'b0;
        end else begin
            r_ready <= (w_next == IDLE) || (w_next == DONE);
            r_done  <= (w_next == DONE);
            r_err   <= w_timeout;
            r_mp_en <= (w_next == ISSUE);
        end
    end

    // Operand latch, pass counter, timeout counter, accumulator and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mp_a <= {WIDTH{1'b0}};
            r_mp_b <= {WIDTH{1'b0}};
            r_mp_i <= {IW{1'b0}};
            r_acc  <= {WIDTH{1'b0}};
            r_tmo  <= {TW{1'b0}};
            r_out  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_mp_a <= a;
            r_mp_b <= b;
            r_mp_i <= {IW{1'b0}};
            r_acc  <= {WIDTH{1'b0}};
            r_tmo  <= {TW{1'b0}};
        end else begin
            case (r_state)
                ISSUE: begin
                    r_tmo <= ONE_T;
                end
                WAIT: begin
                    if (mp_out_valid) begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_out  <= w_sum;
                        end else begin
                            r_mp_i <= r_mp_i + ONE_I;
                        end
                    end else if (w_timeout) begin
                        r_acc <= {WIDTH{1'b0}};
                    end else begin
                        r_tmo <= r_tmo + ONE_T;
                    end
                end
                default: begin
                    r_tmo <= r_tmo;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign err   = r_err;
    assign out   = r_out;
    assign mp_en = r_mp_en;
    assign mp_a  = r_mp_a;
    assign mp_b  = r_mp_b;
    assign mp_i  = r_mp_i;

endmodule
